// File: rtl/stage_pkg.sv
// ============================================================================
// Module      : stage_pkg
// Description : Constants and FSM state type shared by the stage-1 cipher
//               stages (encrypt and decrypt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_pkg;

    localparam int c_WIDTH_DEF     = 16;
    localparam int c_ADD_CONST     = 3;
    localparam int c_KEY_SHIFT_MSB = 4;
    localparam int c_KEY_SHIFT_LSB = 2;
    localparam int c_CNT_W         = c_KEY_SHIFT_MSB - c_KEY_SHIFT_LSB + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB   = 3'd1,
        SHIFT = 3'd2,
        FIN   = 3'd3,
        DONE  = 3'd4
    } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/stage1_dec_if.sv
// ============================================================================
// Module      : stage1_dec_if
// Description : ld/start/done handshake and data bus of the stage-1 decrypt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stage1_dec_if
    import stage_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF
);
    logic [4:0]       key_bits;
    logic [WIDTH-1:0] input_data;
    logic             ld;
    logic             start;
    logic [WIDTH-1:0] stg1_dec_out;
    logic             done;
    logic             busy;
    logic             err;

    modport master (
        output key_bits, input_data, ld, start,
        input  stg1_dec_out, done, busy, err
    );

    modport slave (
        input  key_bits, input_data, ld, start,
        output stg1_dec_out, done, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/stage1_dec_shifter.sv
// ============================================================================
// Module      : stage1_dec_shifter
// Description : Serial one-bit-per-cycle logical right shifter with its
//               shift-count down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage1_dec_shifter
    import stage_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF
) (
    input  wire logic               clk1,
    input  wire logic               rst,
    input  wire logic               i_cnt_load,
    input  wire logic [c_CNT_W-1:0] i_cnt,
    input  wire logic               i_work_load,
    input  wire logic [WIDTH-1:0]   i_work,
    input  wire logic               i_shift,
    output logic      [WIDTH-1:0]   o_work,
    output logic      [c_CNT_W-1:0] o_cnt,
    output logic                    o_cnt_zero,
    output logic                    o_cnt_last
);

    logic [WIDTH-1:0]   r_work;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_cnt_load) begin
                r_cnt <= i_cnt;
            end else if (i_shift) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (i_work_load) begin
                r_work <= i_work;
            end else if (i_shift) begin
                r_work <= {1'b0, r_work[WIDTH-1:1]};
            end
        end
    end

    assign o_work     = r_work;
    assign o_cnt      = r_cnt;
    assign o_cnt_zero = (r_cnt == '0);
    assign o_cnt_last = (r_cnt == c_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/stage1_dec.sv
// ============================================================================
// Module      : stage1_dec
// Description : Stage-1 decrypt: out = ((in - ADD_CONST) mod 2^WIDTH) >> k,
//               k = key_bits[4:2], shifted serially. Optional ciphertext
//               check enabled by macro STG1_DEC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage1_dec
    import stage_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH_DEF,
    parameter int ADD_CONST = c_ADD_CONST
) (
    input  wire logic   clk1,
    input  wire logic   rst,
    stage1_dec_if.slave bus
);

    localparam logic [WIDTH-1:0] c_SUB = WIDTH'(ADD_CONST);

    stage_state_t       r_state;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_out;
    logic               r_done;
    logic               r_busy;

    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_work;
    logic [c_CNT_W-1:0] w_cnt;
    logic               w_cnt_zero;
    logic               w_cnt_last;
    logic               w_unused_key;

    assign w_sub        = r_data - c_SUB;
    assign w_unused_key = ^bus.key_bits[c_KEY_SHIFT_LSB-1:0];

    // ld overrides everything below rst, so it also masks the datapath strobes
    stage1_dec_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk1        (clk1),
        .rst         (rst),
        .i_cnt_load  (!bus.ld && r_state == IDLE && bus.start),
        .i_cnt       (bus.key_bits[c_KEY_SHIFT_MSB:c_KEY_SHIFT_LSB]),
        .i_work_load (!bus.ld && r_state == SUB),
        .i_work      (w_sub),
        .i_shift     (!bus.ld && r_state == SHIFT),
        .o_work      (w_work),
        .o_cnt       (w_cnt),
        .o_cnt_zero  (w_cnt_zero),
        .o_cnt_last  (w_cnt_last)
    );

`ifdef STG1_DEC_CHECK_EN
    logic             r_err;
    logic [WIDTH-1:0] w_low_mask;

    // Nonzero discarded bits mean the word was not produced by the encrypt stage
    assign w_low_mask = ~({WIDTH{1'b1}} << w_cnt);

    always_ff @(posedge clk1) begin
        if (rst || bus.ld) begin
            r_err <= 1'b0;
        end else if (r_state == SUB && (w_sub & w_low_mask) != '0) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (bus.ld) begin
            r_state <= IDLE;
            r_data  <= bus.input_data;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= SUB;
                        r_busy  <= 1'b1;
                    end
                end
                SUB: begin
                    r_state <= w_cnt_zero ? FIN : SHIFT;
                end
                SHIFT: begin
                    if (w_cnt_last) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_out   <= w_work;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stg1_dec_out = r_out;
    assign bus.done         = r_done;
    assign bus.busy         = r_busy;

endmodule

`default_nettype wire
